// File: rtl/mod_plpbot_uart_fifo.sv
// PLP bus UART: programmable baud divisor, optional parity, 1/2 stop bits,
// RX/TX FIFOs and sticky error flags. State updates on the falling clock edge.

module mod_plpbot_uart_fifo_buf #(
   parameter int L = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [7:0]   data_i,
   output logic [7:0]   data_o,
   output logic [L:0]   count_o,
   output logic         ovr_o
);
   localparam int N  = 1 << L;
   localparam int CW = L + 1;

   logic [7:0]   mem_q [N];
   logic [L-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [L:0]   cnt_q, cnt_d;
   logic         full, empty, do_pop, do_push;

   always_comb begin
      full    = (cnt_q == CW'(N));
      empty   = (cnt_q == '0);
      do_pop  = pop_i & ~empty;
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      do_push = push_i & (~full | do_pop);
      ovr_o   = push_i & ~do_push;
      rd_d    = rd_q + L'(do_pop);
      wr_d    = wr_q + L'(do_push);
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
      data_o  = empty ? 8'h00 : mem_q[rd_q];
      count_o = cnt_q;
   end

   always_ff @(negedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   always_ff @(negedge clk_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

module mod_plpbot_uart_fifo #(
   parameter int          FIFO_LOG2   = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd163
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        ie,
   input  logic        de,
   input  logic [31:0] iaddr,
   input  logic [31:0] daddr,
   input  logic [1:0]  drw,
   input  logic [31:0] din,
   output logic [31:0] iout,
   output logic [31:0] dout,
   output logic        txd,
   input  logic        rxd,
   output logic        i_uart,
   output logic        pmc_uart_recv,
   output logic        pmc_uart_send
);
   localparam int CW    = FIFO_LOG2 + 1;
   localparam int DEPTH = 1 << FIFO_LOG2;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT
   } rx_state_e;

   logic        wr, wr_cmd, wr_txbuf, wr_cfg;
   logic        tx_push, rx_pop, err_clr;
   logic [7:0]  txbuf_q, txbuf_d;
   logic [15:0] div_q, div_d, baud_q, baud_d, div_eff;
   logic [1:0]  par_q, par_d;
   logic        stop2_q, stop2_d;
   logic        tick, par_en, par_odd;

   tx_state_e   tx_st_q, tx_st_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [3:0]  tx_tk_q, tx_tk_d;
   logic        tx_par_q, tx_par_d;
   logic        tx_pop, tx_last, tx_empty, tx_nf, tx_idle;
   logic [7:0]  tx_head;
   logic [CW-1:0] tx_cnt;

   rx_state_e   rx_st_q, rx_st_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [3:0]  rx_tk_q, rx_tk_d;
   logic        rx_vld_q, rx_vld_d;
   logic        rx_s1_q, rx_s2_q;
   logic        rx_mid, rx_ne, perr_set, ferr_set;
   logic [7:0]  rx_head;
   logic [CW-1:0] rx_cnt;

   logic        perr_q, perr_d, ferr_q, ferr_d;
   logic        rxovr_q, rxovr_d, txovr_q, txovr_d;
   logic        rx_ovr_ev, tx_ovr_ev;
   logic [31:0] status;
   logic        unused_ok;

   assign unused_ok = ^{ie, iaddr, drw[1], din[31:19]};

   always_comb begin
      wr            = de & drw[0];
      wr_cmd        = wr & (daddr == 32'h0);
      wr_txbuf      = wr & (daddr == 32'hC);
      wr_cfg        = wr & (daddr == 32'h10);
      tx_push       = wr_cmd & din[0];
      rx_pop        = wr_cmd & din[1];
      err_clr       = wr_cmd & din[2];
      pmc_uart_send = tx_push;
      pmc_uart_recv = rx_pop;
      txbuf_d       = wr_txbuf ? din[7:0] : txbuf_q;
      div_d         = wr_cfg ? din[15:0] : div_q;
      par_d         = wr_cfg ? din[17:16] : par_q;
      stop2_d       = wr_cfg ? din[18] : stop2_q;
      div_eff       = (div_q == 16'd0) ? 16'd1 : div_q;
      tick          = (baud_q == div_eff - 16'd1);
      baud_d        = (wr_cfg | tick) ? 16'd0 : baud_q + 16'd1;
      par_en        = (par_q == 2'd1) | (par_q == 2'd2);
      par_odd       = (par_q == 2'd2);
   end

   mod_plpbot_uart_fifo_buf #(.L(FIFO_LOG2)) u_txf (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (tx_push),
      .pop_i   (tx_pop),
      .data_i  (txbuf_q),
      .data_o  (tx_head),
      .count_o (tx_cnt),
      .ovr_o   (tx_ovr_ev)
   );

   mod_plpbot_uart_fifo_buf #(.L(FIFO_LOG2)) u_rxf (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (rx_vld_q),
      .pop_i   (rx_pop),
      .data_i  (rx_sh_q),
      .data_o  (rx_head),
      .count_o (rx_cnt),
      .ovr_o   (rx_ovr_ev)
   );

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_sh_d  = tx_sh_q;
      tx_bit_d = tx_bit_q;
      tx_par_d = tx_par_q;
      tx_tk_d  = tick ? tx_tk_q + 4'd1 : tx_tk_q;
      tx_pop   = 1'b0;
      tx_empty = (tx_cnt == '0);
      tx_last  = tick & (tx_tk_q == 4'hF);
      unique case (tx_st_q)
         TX_IDLE: if (!tx_empty) begin
            tx_pop   = 1'b1;
            tx_sh_d  = tx_head;
            tx_par_d = ^tx_head;
            tx_bit_d = 3'd0;
            tx_tk_d  = 4'd0;
            tx_st_d  = TX_START;
         end
         TX_START: if (tx_last) tx_st_d = TX_DATA;
         TX_DATA: if (tx_last) begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_st_d = par_en ? TX_PAR : TX_STOP1;
         end
         TX_PAR:   if (tx_last) tx_st_d = TX_STOP1;
         TX_STOP1: if (tx_last) tx_st_d = stop2_q ? TX_STOP2 : TX_IDLE;
         TX_STOP2: if (tx_last) tx_st_d = TX_IDLE;
         default:  tx_st_d = TX_IDLE;
      endcase
   end

   always_comb begin
      case (tx_st_q)
         TX_START: txd = 1'b0;
         TX_DATA:  txd = tx_sh_q[0];
         TX_PAR:   txd = tx_par_q ^ par_odd;
         default:  txd = 1'b1;
      endcase
   end

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_sh_d  = rx_sh_q;
      rx_bit_d = rx_bit_q;
      rx_tk_d  = tick ? rx_tk_q + 4'd1 : rx_tk_q;
      rx_vld_d = 1'b0;
      perr_set = 1'b0;
      ferr_set = 1'b0;
      rx_mid   = tick & (rx_tk_q == 4'hF);
      unique case (rx_st_q)
         RX_IDLE: if (tick & ~rx_s2_q) begin
            rx_tk_d = 4'd0;
            rx_st_d = RX_START;
         end
         // Mid-start re-sample: a line back high was only a glitch.
         RX_START: if (tick & (rx_tk_q == 4'd7)) begin
            rx_tk_d  = 4'd0;
            rx_bit_d = 3'd0;
            rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_mid) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = par_en ? RX_PAR : RX_STOP;
         end
         RX_PAR: if (rx_mid) begin
            perr_set = rx_s2_q ^ (^rx_sh_q) ^ par_odd;
            rx_st_d  = RX_STOP;
         end
         RX_STOP: if (rx_mid) begin
            rx_vld_d = rx_s2_q;
            ferr_set = ~rx_s2_q;
            rx_st_d  = rx_s2_q ? RX_IDLE : RX_WAIT;
         end
         RX_WAIT: if (rx_s2_q) rx_st_d = RX_IDLE;
         default: rx_st_d = RX_IDLE;
      endcase
   end

   always_comb begin
      perr_d  = (perr_q & ~err_clr) | perr_set;
      ferr_d  = (ferr_q & ~err_clr) | ferr_set;
      rxovr_d = (rxovr_q & ~err_clr) | rx_ovr_ev;
      txovr_d = (txovr_q & ~err_clr) | tx_ovr_ev;
      tx_nf   = (tx_cnt != CW'(DEPTH));
      rx_ne   = (rx_cnt != '0);
      tx_idle = (tx_st_q == TX_IDLE) & (tx_cnt == '0);
      i_uart  = rx_ne;
      iout    = 32'h0;
      status  = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 1'b0, tx_idle,
                 txovr_q, rxovr_q, ferr_q, perr_q, rx_ne, tx_nf};
      case (daddr)
         32'h04:  dout = status;
         32'h08:  dout = {24'h0, rx_head};
         32'h0C:  dout = {24'h0, txbuf_q};
         32'h10:  dout = {13'h0, stop2_q, par_q, div_q};
         default: dout = 32'h0;
      endcase
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         txbuf_q  <= 8'h00;
         div_q    <= DEFAULT_DIV;
         par_q    <= 2'd0;
         stop2_q  <= 1'b0;
         baud_q   <= 16'd0;
         tx_st_q  <= TX_IDLE;
         tx_sh_q  <= 8'h00;
         tx_bit_q <= 3'd0;
         tx_tk_q  <= 4'd0;
         tx_par_q <= 1'b0;
         rx_st_q  <= RX_IDLE;
         rx_sh_q  <= 8'h00;
         rx_bit_q <= 3'd0;
         rx_tk_q  <= 4'd0;
         rx_vld_q <= 1'b0;
         rx_s1_q  <= 1'b1;
         rx_s2_q  <= 1'b1;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         rxovr_q  <= 1'b0;
         txovr_q  <= 1'b0;
      end else begin
         txbuf_q  <= txbuf_d;
         div_q    <= div_d;
         par_q    <= par_d;
         stop2_q  <= stop2_d;
         baud_q   <= baud_d;
         tx_st_q  <= tx_st_d;
         tx_sh_q  <= tx_sh_d;
         tx_bit_q <= tx_bit_d;
         tx_tk_q  <= tx_tk_d;
         tx_par_q <= tx_par_d;
         rx_st_q  <= rx_st_d;
         rx_sh_q  <= rx_sh_d;
         rx_bit_q <= rx_bit_d;
         rx_tk_q  <= rx_tk_d;
         rx_vld_q <= rx_vld_d;
         rx_s1_q  <= rxd;
         rx_s2_q  <= rx_s1_q;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         rxovr_q  <= rxovr_d;
         txovr_q  <= txovr_d;
      end
   end
endmodule

// File: tb/tb_mod_plpbot_uart_fifo.sv
// Scoreboard bench for mod_plpbot_uart_fifo (4-deep FIFOs, divisor 2).
// Inputs change on the rising edge; the DUT acts on the falling edge.

module tb_mod_plpbot_uart_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ie = 1'b0, de = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, din = '0;
  logic [1:0] drw = '0;
  logic [31:0] iout, dout;
  logic txd, rxd, i_uart, pmc_uart_recv, pmc_uart_send;
  logic loop = 1'b0, rx_drv = 1'b1;

  int n_tests = 0, n_fail = 0;
  int div = 2;
  logic [7:0] sb_q[$];

  assign rxd = loop ? txd : rx_drv;

  always #5 clk = ~clk;

  mod_plpbot_uart_fifo #(.FIFO_LOG2(2), .DEFAULT_DIV(16'd163)) dut (
    .rst(rst), .clk(clk), .ie(ie), .de(de),
    .iaddr(iaddr), .daddr(daddr), .drw(drw), .din(din),
    .iout(iout), .dout(dout), .txd(txd), .rxd(rxd),
    .i_uart(i_uart), .pmc_uart_recv(pmc_uart_recv),
    .pmc_uart_send(pmc_uart_send)
  );

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    de = 1'b1; drw = 2'b01; daddr = a; din = d;
    @(posedge clk);
    de = 1'b0; drw = 2'b00; din = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk);
    daddr = a;
    #1 d = dout;
  endtask

  task automatic wait_rx(input int n, input int lim, output logic [31:0] s);
    int k = 0;
    do begin rd(32'h4, s); k++; end
    while (int'(s[15:8]) != n && k < lim);
  endtask

  task automatic wait_idle(input int lim, output logic [31:0] s);
    int k = 0;
    do begin rd(32'h4, s); k++; end
    while (!s[6] && k < lim);
  endtask

  task automatic pop_rx(output logic [7:0] b);
    logic [31:0] d;
    rd(32'h8, d);
    b = d[7:0];
    wr(32'h0, 32'h2);
  endtask

  task automatic send_tx(input logic [7:0] b);
    wr(32'hC, {24'h0, b});
    wr(32'h0, 32'h1);
    sb_q.push_back(b);
  endtask

  task automatic drive_frame(input logic [7:0] b, input int pm,
                             input logic flip, input logic stopv);
    int bt = 16 * div;
    @(posedge clk);
    rx_drv = 1'b0;
    repeat (bt) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bt) @(posedge clk);
    end
    if (pm == 1 || pm == 2) begin
      rx_drv = (^b) ^ (pm == 2) ^ flip;
      repeat (bt) @(posedge clk);
    end
    rx_drv = stopv;
    repeat (bt) @(posedge clk);
    rx_drv = 1'b1;
    repeat (bt) @(posedge clk);
  endtask

  task automatic measure_tail(output int hi, output logic [31:0] s);
    int cyc = 0, rise = 0;
    logic prev;
    daddr = 32'h4;
    prev = txd;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!prev && txd) rise = cyc;
      prev = txd;
      s = dout;
    end while (!s[6] && cyc < 5000);
    hi = cyc - rise;
  endtask

  task automatic test_reset();
    logic [31:0] s;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (txd !== 1'b1 || i_uart !== 1'b0 || iout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pins: txd=%b i_uart=%b iout=%h want 1 0 0", txd, i_uart, iout);
    end
    rd(32'h4, s);
    n_tests++;
    if (s !== 32'h41) begin n_fail++; $display("FAIL reset_status: got %h want 41", s); end
    rd(32'h10, s);
    n_tests++;
    if (s !== 32'hA3) begin n_fail++; $display("FAIL reset_config: got %h want a3", s); end
    rd(32'hC, s);
    n_tests++;
    if (s !== 32'h0) begin n_fail++; $display("FAIL reset_txbuf: got %h want 0", s); end
    rd(32'h8, s);
    n_tests++;
    if (s !== 32'h0) begin n_fail++; $display("FAIL reset_rxhead: got %h want 0", s); end
    wr(32'h14, 32'hFFFF_FFFF);
    rd(32'h14, s);
    n_tests++;
    if (s !== 32'h0) begin n_fail++; $display("FAIL bad_offset: got %h want 0", s); end
  endtask

  task automatic test_loopback();
    logic [31:0] s;
    logic [7:0] got, exp;
    wr(32'h10, 32'h2);
    loop = 1'b1;
    wr(32'hC, 32'hA5);
    rd(32'hC, s);
    n_tests++;
    if (s !== 32'hA5) begin n_fail++; $display("FAIL txbuf_rw: got %h want a5", s); end
    @(posedge clk);
    de = 1'b1; drw = 2'b01; daddr = 32'h0; din = 32'h1;
    #1;
    n_tests++;
    if (pmc_uart_send !== 1'b1 || pmc_uart_recv !== 1'b0) begin
      n_fail++;
      $display("FAIL pmc_send: got %b%b want 10", pmc_uart_send, pmc_uart_recv);
    end
    @(posedge clk);
    de = 1'b0; drw = 2'b00; din = '0; daddr = 32'h4;
    #1;
    n_tests++;
    if (dout[23:16] !== 8'd1 || txd !== 1'b1) begin
      n_fail++;
      $display("FAIL push_count: tx_count=%0d txd=%b want 1 1", dout[23:16], txd);
    end
    sb_q.push_back(8'hA5);
    @(posedge clk); #1;
    n_tests++;
    if (dout[23:16] !== 8'd0 || txd !== 1'b0) begin
      n_fail++;
      $display("FAIL start_bit: tx_count=%0d txd=%b want 0 0", dout[23:16], txd);
    end
    wait_rx(1, 2000, s);
    n_tests++;
    if (s[15:8] !== 8'd1 || i_uart !== 1'b1) begin
      n_fail++;
      $display("FAIL loop_rx: rx_count=%0d i_uart=%b want 1 1", s[15:8], i_uart);
    end
    pop_rx(got);
    exp = sb_q.pop_front();
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL loop_data: got %h want %h", got, exp); end
    wait_idle(2000, s);
    n_tests++;
    if (s !== 32'h41) begin n_fail++; $display("FAIL loop_status: got %h want 41", s); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    logic [7:0] got, exp;
    logic [7:0] pat [3];
    pat[0] = 8'h11; pat[1] = 8'h7E; pat[2] = 8'hC3;
    loop = 1'b1;
    for (int i = 0; i < 3; i++) send_tx(pat[i]);
    wait_rx(3, 4000, s);
    n_tests++;
    if (s[15:8] !== 8'd3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", s[15:8]); end
    for (int i = 0; i < 3; i++) begin
      pop_rx(got);
      exp = sb_q.pop_front();
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, got, exp); end
    end
    wait_idle(2000, s);
    n_tests++;
    if (s !== 32'h41) begin n_fail++; $display("FAIL b2b_status: got %h want 41", s); end
  endtask

  task automatic test_parity();
    logic [31:0] s;
    logic [7:0] got, exp;
    int k = 0;
    int bt = 16 * div;
    wr(32'h10, 32'h10002);
    loop = 1'b1;
    send_tx(8'h03);
    do begin @(posedge clk); #1; k++; end while (txd !== 1'b0 && k < 100);
    repeat (9 * bt + bt / 2) @(posedge clk);
    #1;
    n_tests++;
    if (txd !== 1'b0) begin n_fail++; $display("FAIL tx_parity_bit: got %b want 0", txd); end
    repeat (bt) @(posedge clk);
    #1;
    n_tests++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL tx_stop_bit: got %b want 1", txd); end
    wait_rx(1, 2000, s);
    n_tests++;
    if (s[15:8] !== 8'd1 || s[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL par_ok: rx_count=%0d perr=%b want 1 0", s[15:8], s[2]);
    end
    pop_rx(got);
    exp = sb_q.pop_front();
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL par_data: got %h want %h", got, exp); end
    wait_idle(2000, s);
    loop = 1'b0;
    rx_drv = 1'b1;
    drive_frame(8'h5A, 1, 1'b1, 1'b1);
    sb_q.push_back(8'h5A);
    wait_rx(1, 200, s);
    n_tests++;
    if (s[15:8] !== 8'd1 || s[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL par_err: rx_count=%0d perr=%b want 1 1", s[15:8], s[2]);
    end
    pop_rx(got);
    exp = sb_q.pop_front();
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL par_err_data: got %h want %h", got, exp); end
    wr(32'h0, 32'h4);
    wr(32'h10, 32'h2);
    rd(32'h4, s);
    n_tests++;
    if (s !== 32'h41) begin n_fail++; $display("FAIL par_clear: got %h want 41", s); end
  endtask

  task automatic test_framing();
    logic [31:0] s;
    loop = 1'b0;
    drive_frame(8'h55, 0, 1'b0, 1'b0);
    rd(32'h4, s);
    n_tests++;
    if (s[3] !== 1'b1 || s[15:8] !== 8'd0 || i_uart !== 1'b0) begin
      n_fail++;
      $display("FAIL framing: ferr=%b rx_count=%0d i_uart=%b want 1 0 0", s[3], s[15:8], i_uart);
    end
    wr(32'h0, 32'h4);
    rd(32'h4, s);
    n_tests++;
    if (s !== 32'h41) begin n_fail++; $display("FAIL ferr_clear: got %h want 41", s); end
  endtask

  task automatic test_glitch();
    logic [31:0] s;
    loop = 1'b0;
    @(posedge clk);
    rx_drv = 1'b0;
    repeat (3 * div) @(posedge clk);
    rx_drv = 1'b1;
    repeat (20 * 16 * div) @(posedge clk);
    rd(32'h4, s);
    n_tests++;
    if (s !== 32'h41) begin n_fail++; $display("FAIL glitch: status got %h want 41", s); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] s;
    logic [7:0] got, exp;
    logic [7:0] pat [5];
    int mcnt = 0;
    pat[0] = 8'h01; pat[1] = 8'h80; pat[2] = 8'hFF; pat[3] = 8'h00; pat[4] = 8'h6C;
    loop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_frame(pat[i], 0, 1'b0, 1'b1);
      if (mcnt < 4) begin sb_q.push_back(pat[i]); mcnt++; end
    end
    rd(32'h4, s);
    n_tests++;
    if (s[15:8] !== 8'd4 || s[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_ovr: rx_count=%0d rx_ovr=%b want 4 1", s[15:8], s[4]);
    end
    rd(32'h8, s);
    n_tests++;
    if (s[7:0] !== sb_q[0]) begin n_fail++; $display("FAIL ovr_head: got %h want %h", s[7:0], sb_q[0]); end
    for (int i = 0; i < 4; i++) begin
      pop_rx(got);
      exp = sb_q.pop_front();
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL ovr_data%0d: got %h want %h", i, got, exp); end
    end
    wr(32'h0, 32'h6);
    rd(32'h4, s);
    n_tests++;
    if (s !== 32'h41) begin n_fail++; $display("FAIL ovr_clear: got %h want 41", s); end
  endtask

  task automatic test_stop_bits();
    logic [31:0] s;
    logic [7:0] got, exp;
    int hi;
    loop = 1'b1;
    wr(32'h10, 32'h40002);
    send_tx(8'h03);
    measure_tail(hi, s);
    n_tests++;
    if (hi != 32 * div) begin n_fail++; $display("FAIL two_stop: high %0d clk want %0d", hi, 32 * div); end
    wait_rx(1, 200, s);
    pop_rx(got);
    exp = sb_q.pop_front();
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL two_stop_data: got %h want %h", got, exp); end
    wr(32'h10, 32'h2);
    send_tx(8'h03);
    measure_tail(hi, s);
    n_tests++;
    if (hi != 16 * div) begin n_fail++; $display("FAIL one_stop: high %0d clk want %0d", hi, 16 * div); end
    wait_rx(1, 200, s);
    pop_rx(got);
    exp = sb_q.pop_front();
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL one_stop_data: got %h want %h", got, exp); end
  endtask

  task automatic test_tx_full();
    logic [31:0] s;
    loop = 1'b0;
    rx_drv = 1'b1;
    wr(32'h10, 32'hFFFF);
    for (int i = 0; i < 5; i++) begin
      wr(32'hC, 32'h30 + i);
      wr(32'h0, 32'h1);
    end
    rd(32'h4, s);
    n_tests++;
    if (s[23:16] !== 8'd4 || s[5] !== 1'b0 || s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_fill: tx_count=%0d tx_ovr=%b nf=%b want 4 0 0", s[23:16], s[5], s[0]);
    end
    wr(32'h0, 32'h1);
    rd(32'h4, s);
    n_tests++;
    if (s[23:16] !== 8'd4 || s[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_ovr: tx_count=%0d tx_ovr=%b want 4 1", s[23:16], s[5]);
    end
    @(posedge clk);
    de = 1'b1; drw = 2'b01; daddr = 32'h0; din = 32'h3;
    #1;
    n_tests++;
    if (pmc_uart_send !== 1'b1 || pmc_uart_recv !== 1'b1) begin
      n_fail++;
      $display("FAIL pmc_both: got %b%b want 11", pmc_uart_send, pmc_uart_recv);
    end
    @(posedge clk);
    de = 1'b0; drw = 2'b00; din = '0; daddr = 32'h4;
    #1;
    n_tests++;
    if (pmc_uart_send !== 1'b0 || pmc_uart_recv !== 1'b0 || dout[23:16] !== 8'd4 || txd !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd3_full: pmc=%b%b tx_count=%0d txd=%b want 00 4 0",
               pmc_uart_send, pmc_uart_recv, dout[23:16], txd);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL midframe_reset: txd got %b want 1", txd); end
    rst = 1'b0;
    rd(32'h4, s);
    n_tests++;
    if (s !== 32'h41) begin n_fail++; $display("FAIL post_reset_status: got %h want 41", s); end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_parity();
    test_framing();
    test_glitch();
    test_rx_overflow();
    test_stop_bits();
    test_tx_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
